// File: rtl/event_byte_decoder.sv
// Reassembles a serial byte stream into 7-byte DVS event packets (header, x, y, t)
// and presents each event on a valid/ready output register; drops and counts bad packets.
module event_byte_decoder #(
    parameter logic [3:0] SYNC_NIBBLE = 4'hE,
    parameter int         TIMEOUT     = 64,
    parameter int         TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] x_out,
    output logic [15:0] y_out,
    output logic [15:0] t_out,
    output logic        p_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        in_sync,
    output logic [7:0]  err_cnt
);

    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        XH   = 3'd1,
        XL   = 3'd2,
        YH   = 3'd3,
        YL   = 3'd4,
        TH   = 3'd5,
        TL   = 3'd6
    } state_t;

    state_t          state;
    logic [TO_W-1:0] idle_cnt;
    logic [15:0]     x_sh;
    logic [15:0]     y_sh;
    logic [7:0]      t_hi;
    logic            p_sh;

    logic stalled;
    logic accept;
    logic header_ok;
    logic bad_header;
    logic timeout_hit;

    // Only the final byte can stall: it needs a free (or draining) output register.
    assign stalled     = (state == TL) && out_valid && !out_ready;
    assign in_ready    = !stalled;
    assign accept      = in_valid && in_ready;
    assign header_ok   = (in_data[7:4] == SYNC_NIBBLE) && (in_data[3:1] == 3'b000);
    assign bad_header  = accept && (state == HUNT) && !header_ok;
    assign timeout_hit = (TIMEOUT != 0) && !accept && !stalled && (state != HUNT)
                         && (idle_cnt == TO_LAST);
    assign in_sync     = (state != HUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            idle_cnt  <= '0;
            x_sh      <= '0;
            y_sh      <= '0;
            t_hi      <= '0;
            p_sh      <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            t_out     <= '0;
            p_out     <= 1'b0;
            out_valid <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if ((bad_header || timeout_hit) && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end

            // A load in TL below overrides this clear when both happen together.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                idle_cnt <= '0;
                case (state)
                    HUNT: begin
                        if (header_ok) begin
                            p_sh  <= in_data[0];
                            state <= XH;
                        end
                    end
                    XH: begin
                        x_sh[15:8] <= in_data;
                        state      <= XL;
                    end
                    XL: begin
                        x_sh[7:0] <= in_data;
                        state     <= YH;
                    end
                    YH: begin
                        y_sh[15:8] <= in_data;
                        state      <= YL;
                    end
                    YL: begin
                        y_sh[7:0] <= in_data;
                        state     <= TH;
                    end
                    TH: begin
                        t_hi  <= in_data;
                        state <= TL;
                    end
                    TL: begin
                        x_out     <= x_sh;
                        y_out     <= y_sh;
                        t_out     <= {t_hi, in_data};
                        p_out     <= p_sh;
                        out_valid <= 1'b1;
                        state     <= HUNT;
                    end
                    default: state <= HUNT;
                endcase
            end else if (timeout_hit) begin
                state    <= HUNT;
                idle_cnt <= '0;
            end else if ((TIMEOUT != 0) && (state != HUNT) && !stalled) begin
                idle_cnt <= idle_cnt + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_event_byte_decoder.sv
// Randomised scoreboard bench for event_byte_decoder: a packet-level byte-queue model
// predicts events and error counts; a negedge monitor pops and compares each handshake.
module tb_event_byte_decoder;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x_out;
    logic [15:0] y_out;
    logic [15:0] t_out;
    logic        p_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        in_sync;
    logic [7:0]  err_cnt;

    event_byte_decoder #(
        .SYNC_NIBBLE(4'hE),
        .TIMEOUT(TIMEOUT),
        .TO_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .x_out(x_out),
        .y_out(y_out),
        .t_out(t_out),
        .p_out(p_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .in_sync(in_sync),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] t;
        logic        p;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] pend[$];
    int         model_err = 0;
    int         gap = 0;
    int         checks = 0;
    int         errors = 0;
    int         st3 = 0;
    bit         stop_toggle = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, got, expv);
        end
    endtask

    function automatic void model_bump();
        if (model_err < 255) model_err++;
    endfunction

    // Reference model: collect bytes of the current packet and decode when seven arrive.
    function automatic void model_byte(input logic [7:0] b);
        ev_t e;
        if (pend.size() == 0) begin
            if (b[7:4] == 4'hE && b[3:1] == 3'b000) pend.push_back(b);
            else model_bump();
        end else begin
            pend.push_back(b);
            if (pend.size() == 7) begin
                e.x = 16'(pend[1]) * 16'd256 + 16'(pend[2]);
                e.y = 16'(pend[3]) * 16'd256 + 16'(pend[4]);
                e.t = 16'(pend[5]) * 16'd256 + 16'(pend[6]);
                e.p = pend[0][0];
                exp_q.push_back(e);
                pend.delete();
            end
        end
    endfunction

    function automatic void model_idle_cycle();
        gap++;
        if (pend.size() > 0 && gap >= TIMEOUT) begin
            pend.delete();
            model_bump();
            gap = 0;
        end
    endfunction

    function automatic void model_reset();
        pend.delete();
        exp_q.delete();
        model_err = 0;
        gap = 0;
    endfunction

    task automatic applyStimulus(input logic [7:0] b, output int stalls);
        stalls = 0;
        in_data = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready_timeout got 0 expected 1");
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            gap = 0;
            model_byte(b);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            model_idle_cycle();
        end
    endtask

    task automatic send_pkt(input logic [55:0] v);
        int s;
        for (int i = 0; i < 7; i++) applyStimulus(v[55-8*i -: 8], s);
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        idle(3);
        checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_state(input string tag);
        checkOutput({tag, "_err_cnt"}, 32'(err_cnt), 32'(model_err));
        checkOutput({tag, "_in_sync"}, 32'(in_sync), 32'(pend.size() != 0));
    endtask

    // Monitor: every output handshake must match the oldest predicted event.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event got x=%h y=%h t=%h p=%0d expected none",
                         x_out, y_out, t_out, p_out);
            end else begin
                e = exp_q.pop_front();
                checkOutput("ev_x", 32'(x_out), 32'(e.x));
                checkOutput("ev_y", 32'(y_out), 32'(e.y));
                checkOutput("ev_t", 32'(t_out), 32'(e.t));
                checkOutput("ev_p", 32'(p_out), 32'(e.p));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin : main
        int s;
        logic [7:0] b;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_x_out", 32'(x_out), 32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rst_in_sync", 32'(in_sync), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(2);

        $display("[TB] basic packet");
        send_pkt(56'hE1_01_23_00_45_12_34);
        checkOutput("t1_valid", 32'(out_valid), 32'd1);
        checkOutput("t1_x", 32'(x_out), 32'h0123);
        checkOutput("t1_y", 32'(y_out), 32'h0045);
        checkOutput("t1_t", 32'(t_out), 32'h1234);
        checkOutput("t1_p", 32'(p_out), 32'd1);
        drain();
        check_state("t1");

        $display("[TB] bad headers");
        applyStimulus(8'h7F, s);
        applyStimulus(8'hE2, s);
        send_pkt(56'hE0_00_0A_00_0B_00_0C);
        checkOutput("t2_err", 32'(err_cnt), 32'd2);
        drain();
        check_state("t2");

        $display("[TB] back-pressure");
        out_ready = 1'b0;
        send_pkt(56'hE1_11_22_33_44_55_66);
        checkOutput("t3_first_valid", 32'(out_valid), 32'd1);
        fork
            begin
                for (int i = 0; i < 6; i++) applyStimulus(8'hE0 + 8'(i), s);
                applyStimulus(8'h5A, st3);
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                checkOutput("t3_hold_x", 32'(x_out), 32'h1122);
                checkOutput("t3_hold_t", 32'(t_out), 32'h5566);
                checkOutput("t3_hold_valid", 32'(out_valid), 32'd1);
                checkOutput("t3_in_ready_low", 32'(in_ready), 32'd0);
                out_ready = 1'b1;
            end
        join
        checkOutput("t3_stalled", 32'(st3 > 0), 32'd1);
        drain();
        check_state("t3");

        $display("[TB] timeout");
        applyStimulus(8'hE1, s);
        applyStimulus(8'h00, s);
        idle(TIMEOUT);
        checkOutput("t4_in_sync", 32'(in_sync), 32'd0);
        checkOutput("t4_err", 32'(err_cnt), 32'd3);
        send_pkt(56'hE0_12_34_56_78_9A_BC);
        drain();
        applyStimulus(8'hE1, s);
        applyStimulus(8'h00, s);
        idle(TIMEOUT - 1);
        checkOutput("t4_no_timeout_sync", 32'(in_sync), 32'd1);
        applyStimulus(8'h07, s);
        applyStimulus(8'h00, s);
        applyStimulus(8'h08, s);
        applyStimulus(8'h00, s);
        applyStimulus(8'h09, s);
        drain();
        checkOutput("t4_err_after", 32'(err_cnt), 32'd3);
        check_state("t4");

        $display("[TB] reset mid-packet");
        applyStimulus(8'hE1, s);
        applyStimulus(8'hAB, s);
        applyStimulus(8'hCD, s);
        applyStimulus(8'hEF, s);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checkOutput("t5_x", 32'(x_out), 32'd0);
        checkOutput("t5_t", 32'(t_out), 32'd0);
        checkOutput("t5_p", 32'(p_out), 32'd0);
        checkOutput("t5_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_in_sync", 32'(in_sync), 32'd0);
        checkOutput("t5_err", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_pkt(56'hE0_00_01_00_02_00_03);
        drain();
        check_state("t5");

        $display("[TB] random with back-pressure");
        stop_toggle = 0;
        fork
            begin
                while (!stop_toggle) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        applyStimulus(8'($urandom), s);
                    end else begin
                        for (int j = 0; j < 7; j++) begin
                            b = (j == 0) ? {4'hE, 3'b000, 1'($urandom)} : 8'($urandom);
                            applyStimulus(b, s);
                            idle($urandom_range(0, 3));
                        end
                    end
                end
                stop_toggle = 1;
            end
        join
        drain();
        check_state("rand_bp");

        $display("[TB] random with long gaps");
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            for (int j = 0; j < 7; j++) begin
                b = (j == 0) ? {4'hE, 3'b000, 1'($urandom)} : 8'($urandom);
                applyStimulus(b, s);
                if ($urandom_range(0, 9) == 0) idle($urandom_range(58, 70));
                else idle($urandom_range(0, 2));
            end
        end
        drain();
        check_state("rand_gap");

        $display("[TB] error saturation");
        repeat (300) applyStimulus(8'h00, s);
        checkOutput("t6_err_sat", 32'(err_cnt), 32'hFF);
        check_state("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
